single_port_sync_ram_be: RTL
============================

# single_port_sync_ram_be

Parametrised single-port synchronous RAM with per-byte write enables, a selectable output register stage, a read-valid/error strobe, and a hardware clear sequencer that zeroes every word after reset. It is the next-generation replacement for the plain tri-state single-port RAM. It sits behind a bus-side controller and uses split read and write data buses instead of an inout bus.

## Interface
Parameters:
- ADDR_WIDTH, 4, address bus width.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DEPTH, 16, number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  1  access request (chip select).
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_WIDTH  word address.
- wdata  in  DATA_WIDTH  write data.
- be  in  DATA_WIDTH/8  byte enables; bit i controls wdata[8i+7:8i].
- ready  out  1  1 = clear done and accepting requests.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  one-cycle pulse when rdata carries a new read result.
- rerr  out  1  pulses with rvalid when the read address was out of range.

## Operation
- FSM states are CLEAR and RUN. Reset forces CLEAR with clr_cnt=0.
- CLEAR: on each edge, write all-zero to mem[clr_cnt] and increment clr_cnt.
  - When the edge that clears word DEPTH-1 occurs, go to RUN.
  - ready=0 in CLEAR and 1 in RUN.
  - req is ignored in CLEAR: no write, no rvalid.
- An access is accepted on an edge when ready & req. At most one access per cycle; req may be held high for back-to-back accesses.
- Accepted write (we=1):
  - If addr < DEPTH, for every i with be[i]=1, byte i of mem[addr] takes byte i of wdata. Bytes with be[i]=0 are unchanged.
  - If addr ≥ DEPTH, the write is dropped silently. No rerr for writes.
  - be=0 is a legal no-op write.
- Accepted read (we=0):
  - If addr < DEPTH, the result is mem[addr] as it was before that edge.
  - If addr ≥ DEPTH, the result is 0 and rerr pulses with rvalid.
- Writes never produce rvalid.
- rdata holds the last read result until the next rvalid. It is not cleared by writes or idle cycles.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately.
  - Any in-flight read result (OUT_REG=1 pipeline) is discarded.
  - Clearing restarts from word 0, so memory contents are all-zero again after CLEAR.

## Timing
- Reset values: ready=0, rvalid=0, rerr=0, rdata=0. The internal pipeline valid bit is 0.
- CLEAR lasts exactly DEPTH rising edges after rst_n deasserts. ready goes to 1 after the DEPTH-th edge. The first request can be accepted on edge DEPTH+1.
- Read accepted on edge N:
  - OUT_REG=0: rdata, rvalid and rerr are updated by edge N and visible in cycle N+1.
  - OUT_REG=1: they are updated by edge N+1 and visible in cycle N+2.
- Throughput is one access per cycle in both modes. Back-to-back reads produce back-to-back rvalid pulses in order.
- Write accepted on edge N, read of the same address accepted on edge N+1: the read returns the new data.
- Read and write to the same address on the same edge is impossible (single port).
- rvalid and rerr are single-cycle unless the next accepted access is also a read.

## Test plan
- Reset/clear:
  - Pre-fill via writes, pulse rst_n low, then release.
  - Required: ready=0 for exactly DEPTH=16 edges, then 1.
  - Reads of addr 0..15 all return 0 with rvalid=1 and rerr=0.
- Byte enables:
  - Write 0xAABBCCDD to addr 3 with be=4'b1111, then write 0x11223344 with be=4'b0101.
  - Read addr 3 -> rdata=0xAA22CC44.
- Latency:
  - Write 0x12345678 to addr 5, then read addr 5 on edge N.
  - OUT_REG=0: rvalid=1 and rdata=0x12345678 in cycle N+1.
  - OUT_REG=1: same values in cycle N+2 only.
  - Back-to-back reads of addr 5 then 6 -> consecutive rvalid pulses with matching data.
- Out-of-range (DEPTH=12, ADDR_WIDTH=4):
  - Write 0xFFFFFFFF to addr 13 -> dropped.
  - Read addr 13 -> rdata=0, rvalid=1, rerr=1.
  - Contents of addr 0..11 are unchanged.
- Requests during clear: assert req with we=1 to addr 2 during CLEAR -> after ready, read addr 2 returns 0 and no rvalid appeared during CLEAR.
- Reset mid-read (OUT_REG=1): accept a read, then assert rst_n low before the result edge -> rvalid never pulses, rdata=0, and clear restarts from word 0.

Source files
------------

// File: rtl/single_port_sync_ram_be_if.sv
// Request/response bundle between a bus-side controller and the byte-enable RAM.
// The master drives the request fields; the slave returns ready and read results.
interface single_port_sync_ram_be_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    rerr;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata, rvalid, rerr
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata, rvalid, rerr
    );
endinterface

// File: rtl/single_port_sync_ram_be.sv
// Single-port RAM with byte enables that zeroes itself after reset before accepting requests.
// Read latency 1 cycle (OUT_REG=0) or 2 (OUT_REG=1); ready=0 during the clear sweep is the only backpressure.
module single_port_sync_ram_be #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int OUT_REG    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    single_port_sync_ram_be_if.slave   bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [ADDR_WIDTH-1:0]   w_clr_cnt_nxt;
    logic                    w_clr_wr;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_ready;
    logic                    w_in_range;
    logic                    w_wr_acc;
    logic                    w_rd_acc;

    logic                    r_s1_vld;
    logic                    r_s1_err;
    logic [DATA_WIDTH-1:0]   r_s1_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_wr      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_wr      = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
                if (r_clr_cnt == LAST_WORD) begin
                    w_state_nxt   = S_RUN;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    assign w_ready    = (r_state == S_RUN);
    // Extra top bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    assign w_in_range = ({1'b0, bus.addr} < (ADDR_WIDTH + 1)'(DEPTH));
    assign w_wr_acc   = w_ready & bus.req & bus.we & w_in_range;
    assign w_rd_acc   = w_ready & bus.req & ~bus.we;

    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) begin
                    r_mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Data is only reloaded on a read so the last result persists through writes and idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_err <= 1'b0;
            r_s1_dat <= '0;
        end else begin
            r_s1_vld <= w_rd_acc;
            r_s1_err <= w_rd_acc & ~w_in_range;
            if (w_rd_acc) begin
                r_s1_dat <= w_in_range ? r_mem[bus.addr] : '0;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  r_s2_vld;
            logic                  r_s2_err;
            logic [DATA_WIDTH-1:0] r_s2_dat;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_vld <= 1'b0;
                    r_s2_err <= 1'b0;
                    r_s2_dat <= '0;
                end else begin
                    r_s2_vld <= r_s1_vld;
                    r_s2_err <= r_s1_err;
                    if (r_s1_vld) begin
                        r_s2_dat <= r_s1_dat;
                    end
                end
            end

            assign bus.rvalid = r_s2_vld;
            assign bus.rerr   = r_s2_err;
            assign bus.rdata  = r_s2_dat;
        end else begin : g_noreg
            assign bus.rvalid = r_s1_vld;
            assign bus.rerr   = r_s1_err;
            assign bus.rdata  = r_s1_dat;
        end
    endgenerate

    assign bus.ready = w_ready;

endmodule
